// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu_ctrl instruction sequencer.
// Holds the op encoding, FSM states and instruction field positions.
package alu_ctrl_pkg;

    localparam int unsigned DataWidth    = 8;
    localparam int unsigned NumRegs      = 4;
    localparam int unsigned RegAddrWidth = 2;
    localparam int unsigned InstrWidth   = 16;

    // Instruction field positions
    localparam int unsigned OpMsb     = 15;
    localparam int unsigned OpLsb     = 14;
    localparam int unsigned ImmSelBit = 13;
    localparam int unsigned RdMsb     = 12;
    localparam int unsigned RdLsb     = 11;
    localparam int unsigned Rs1Msb    = 10;
    localparam int unsigned Rs1Lsb    = 9;
    localparam int unsigned ResvBit   = 8;
    localparam int unsigned ImmMsb    = 7;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned Rs2Msb    = 1;
    localparam int unsigned Rs2Lsb    = 0;

    typedef enum logic [1:0] {
        OpAnd = 2'b00,
        OpOr  = 2'b01,
        OpAdd = 2'b10,
        OpSub = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        alu_op_e                 op;
        logic                    immsel;
        logic [RegAddrWidth-1:0] rd;
        logic [RegAddrWidth-1:0] rs1;
        logic [DataWidth-1:0]    imm8;
    } instr_t;

    // {zero, neg, ovf} of a result given the operands that produced it.
    function automatic logic [2:0] calc_flags(input alu_op_e              op,
                                              input logic [DataWidth-1:0] op_a,
                                              input logic [DataWidth-1:0] op_b,
                                              input logic [DataWidth-1:0] res);
        logic zero;
        logic neg;
        logic ovf;
        zero = (res == '0);
        neg  = res[DataWidth-1];
        ovf  = 1'b0;
        unique case (op)
            OpAdd: ovf = (op_a[DataWidth-1] == op_b[DataWidth-1]) &&
                         (res[DataWidth-1] != op_a[DataWidth-1]);
            OpSub: ovf = (op_a[DataWidth-1] != op_b[DataWidth-1]) &&
                         (res[DataWidth-1] != op_a[DataWidth-1]);
            default: ovf = 1'b0;
        endcase
        return {zero, neg, ovf};
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
// R0 always reads zero and ignores writes.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [RegAddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0]    wdata,
    input  logic [RegAddrWidth-1:0] raddr_a,
    output logic [DataWidth-1:0]    rdata_a,
    input  logic [RegAddrWidth-1:0] raddr_b,
    output logic [DataWidth-1:0]    rdata_b
);

    logic [DataWidth-1:0] regs_q [NumRegs];

    // Reset has priority, so a write pending on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    end

endmodule

// File: rtl/alu_ctrl.sv
// Single-issue controller that sequences instructions through an external ALU.
// IDLE accepts, EXEC drives operands and writes back, RESP holds the result.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [InstrWidth-1:0]       instr,
    output logic signed [DataWidth-1:0] a,
    output logic signed [DataWidth-1:0] b,
    output logic [1:0]                  ALUControl,
    input  logic signed [DataWidth-1:0] ALUResult,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DataWidth-1:0]        res_data,
    output logic [RegAddrWidth-1:0]     res_rd,
    output logic [2:0]                  flags
);

    ctrl_state_e state_q, state_d;
    instr_t      instr_q, instr_d;

    logic [DataWidth-1:0]    res_data_q;
    logic [RegAddrWidth-1:0] res_rd_q;
    logic [2:0]              flags_q, flags_d;

    logic [DataWidth-1:0] rdata_a;
    logic [DataWidth-1:0] rdata_b;
    logic                 in_exec;

    logic unused_resv;
    assign unused_resv = instr[ResvBit];

    assign in_exec = (state_q == StExec);

    alu_ctrl_regfile u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (in_exec),
        .waddr   (instr_q.rd),
        .wdata   (ALUResult),
        .raddr_a (instr_q.rs1),
        .rdata_a (rdata_a),
        .raddr_b (instr_q.imm8[Rs2Msb:Rs2Lsb]),
        .rdata_b (rdata_b)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d        = StExec;
                    instr_d.op     = alu_op_e'(instr[OpMsb:OpLsb]);
                    instr_d.immsel = instr[ImmSelBit];
                    instr_d.rd     = instr[RdMsb:RdLsb];
                    instr_d.rs1    = instr[Rs1Msb:Rs1Lsb];
                    instr_d.imm8   = instr[ImmMsb:ImmLsb];
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operands are only presented during EXEC; otherwise the ALU sees zeros.
    always_comb begin
        a          = '0;
        b          = '0;
        ALUControl = '0;
        if (in_exec) begin
            a          = rdata_a;
            b          = instr_q.immsel ? instr_q.imm8 : rdata_b;
            ALUControl = instr_q.op;
        end
    end

    always_comb begin
        flags_d = calc_flags(instr_q.op, a, b, ALUResult);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            if (in_exec) begin
                res_data_q <= ALUResult;
                res_rd_q   <= instr_q.rd;
                flags_q    <= flags_d;
            end
        end
    end

    assign res_valid = (state_q == StResp);
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign flags     = flags_q;

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 8, register count fixed at 4.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  controller accepts instruction.
REQ-006 instr  input  16  [15:14] op, [13] immsel, [12:11] rd, [10:9] rs1, [8] reserved, [7:0] imm8 (immsel=1) or [1:0] rs2 (immsel=0).
REQ-007 a  output  8 signed  ALU operand A.
REQ-008 b  output  8 signed  ALU operand B.
REQ-009 ALUControl  output  2  ALU operation: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-010 ALUResult  input  8 signed  combinational ALU result for current a/b/ALUControl.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  result consumer accepts.
REQ-013 res_data  output  8  result value.
REQ-014 res_rd  output  2  destination register of result.
REQ-015 flags  output  3  {zero, neg, ovf} of result.

Function
REQ-016 FSM states IDLE, EXEC, RESP; IDLE->EXEC on instr_valid&&instr_ready; EXEC->RESP unconditionally; RESP->IDLE on res_ready.
REQ-017 instr_ready SHALL be 1 only in IDLE; instruction latched on the handshake cycle.
REQ-018 In EXEC: a=R[rs1]; b=imm8 if immsel else R[rs2]; ALUControl=op.
REQ-019 Outside EXEC, a, b, ALUControl SHALL be driven 0.
REQ-020 ALUResult sampled at end of EXEC into res_data; res_rd=rd; flags computed same edge.
REQ-021 zero = (result==0); neg = result[7].
REQ-022 ovf: ADD -> a[7]==b[7] && result[7]!=a[7]; SUB -> a[7]!=b[7] && result[7]!=a[7]; AND/OR -> 0.
REQ-023 Register file 4x8; R[rd] written with result on EXEC->RESP edge; R0 hardwired 0, writes to rd=0 discarded (res_data still reports result).
REQ-024 Latency: handshake in cycle N, EXEC in N+1, res_valid=1 from N+2; minimum 3 cycles per instruction, no overlap.
REQ-025 In RESP, res_valid, res_data, res_rd, flags SHALL hold stable until res_ready; res_ready while res_valid=0 ignored.
REQ-026 instr[8] ignored; instr_valid outside IDLE ignored (no capture).
REQ-027 A following instruction reading the previous rd SHALL see the written value (no hazard window).

Reset
REQ-028 reset_n=0 at a rising edge: state->IDLE, R1..R3=0, res_valid=0, res_data=0, res_rd=0, flags=0, latched instruction cleared.
REQ-029 Reset in EXEC or RESP SHALL abort the operation: no register write, result discarded, instr_ready=1 on first cycle after release.

Structure
REQ-030 Shared package alu_ctrl_pkg holds: op encoding enum (AND/OR/ADD/SUB), FSM state enum, instruction field bit positions, width constant 8.
REQ-031 One sub-module natural: alu_ctrl_regfile (4x8, two combinational read ports, one sync write port, R0 constant 0).

Verification
REQ-032 Reset; ADD imm rd=1 rs1=0 imm=0x05 -> res_valid at N+2, res_data=0x05, res_rd=1, flags=000.
REQ-033 R1=0x7F (ADD imm), then ADD imm rd=2 rs1=1 imm=0x01 -> res_data=0x80, flags=011 (neg, ovf).
REQ-034 SUB reg rd=3 rs1=0 rs2=0 -> 0x00 flags=100; SUB imm rs1=0 imm=0x01 -> 0xFF flags=010.
REQ-035 ADD imm rd=0 imm=0x33 -> res_data=0x33; next OR reg rs1=0 rs2=0 -> res_data=0x00.
REQ-036 Hold res_ready=0 for 5 cycles in RESP -> res_valid/res_data/flags constant, instr_ready=0, a/b/ALUControl=0.
REQ-037 reset_n=0 during EXEC of write to R2 -> after release instr_ready=1, res_valid=0, subsequent read of R2 returns 0x00.
